sdram_model: RTL

SDRAM_MODEL -- requirements
Module: sdram_model

---
 rtl/sdram_pkg.sv | 55 +++++
 rtl/sdram_model_bank.sv | 74 +++++++
 rtl/sdram_model.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM behavioural model: command encodings,
// mode-register field positions, violation codes and read-pipeline types.
package sdram_pkg;

    typedef enum logic [2:0] {
        CmdLoadMode  = 3'b000,
        CmdRefresh   = 3'b001,
        CmdPrecharge = 3'b010,
        CmdActive    = 3'b011,
        CmdWrite     = 3'b100,
        CmdRead      = 3'b101,
        CmdBurstTerm = 3'b110,
        CmdNop       = 3'b111
    } sdram_cmd_e;

    typedef enum logic {
        BankIdle,
        BankActive
    } bank_state_e;

    localparam int unsigned ModeBlLsb = 0;
    localparam int unsigned ModeBlMsb = 2;
    localparam int unsigned ModeClLsb = 4;
    localparam int unsigned ModeClMsb = 6;
    localparam int unsigned MaxCl     = 3;

    typedef logic [2:0] err_code_t;

    localparam err_code_t ErrNone       = 3'd0;
    localparam err_code_t ErrIdleBank   = 3'd1;
    localparam err_code_t ErrBankActive = 3'd2;
    localparam err_code_t ErrTrcd       = 3'd3;
    localparam err_code_t ErrNotIdle    = 3'd4;
    localparam err_code_t ErrNoMode     = 3'd5;
    localparam err_code_t ErrBadMode    = 3'd6;

    typedef struct packed {
        logic        vld;
        logic [15:0] data;
    } rd_slot_t;

    // Anything other than CL=3 falls back to CL=2.
    function automatic int unsigned cas_latency(input logic [12:0] mode);
        return (mode[ModeClMsb:ModeClLsb] == 3'd3) ? 3 : 2;
    endfunction

    function automatic logic mode_supported(input logic [12:0] mode);
        logic [2:0] cl;
        logic [2:0] bl;
        cl = mode[ModeClMsb:ModeClLsb];
        bl = mode[ModeBlMsb:ModeBlLsb];
        return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'd0);
    endfunction

endpackage

// File: rtl/sdram_model_bank.sv
// One SDRAM bank: IDLE/ACTIVE state, open-row latch and, with
// SDRAM_MODEL_CHECK_EN defined, an ACTIVE-to-access (tRCD) countdown.
module sdram_model_bank
    import sdram_pkg::*;
#(
    parameter int unsigned TRCD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        act,
    input  logic        pre,
    input  logic [12:0] row_in,
    output logic        active,
    output logic [12:0] row,
    output logic        trcd_ok
);

    bank_state_e state_q, state_d;
    logic [12:0] row_q;
    logic        open_row;

    // An ACTIVE to an already open bank must not move the row.
    assign open_row = act && (state_q == BankIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BankIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BankIdle:   if (act) state_d = BankActive;
            BankActive: if (pre) state_d = BankIdle;
            default:    state_d = BankIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
        end else if (open_row) begin
            row_q <= row_in;
        end
    end

    assign active = (state_q == BankActive);
    assign row    = row_q;

`ifdef SDRAM_MODEL_CHECK_EN
    localparam int unsigned CntW     = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam int unsigned TrcdLoad = (TRCD > 0) ? TRCD - 1 : 0;

    logic [CntW-1:0] trcd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trcd_q <= '0;
        end else if (open_row) begin
            trcd_q <= CntW'(TrcdLoad);
        end else if (trcd_q != '0) begin
            trcd_q <= trcd_q - CntW'(1);
        end
    end

    assign trcd_ok = (trcd_q == '0);
`else
    assign trcd_ok = 1'b1;
`endif

endmodule

// File: rtl/sdram_model.sv
// Behavioural single-word SDRAM device model with protocol checking.
// Define SDRAM_MODEL_CHECK_EN to enable the err/err_code violation reporting.
module sdram_model
    import sdram_pkg::*;
#(
    parameter int unsigned MEM_AW = 16,
    parameter int unsigned TRCD   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [12:0] sd_a,
    input  logic [1:0]  sd_ba,
    input  logic        sd_dqmh,
    input  logic        sd_dqml,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic        sd_dq_oe,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_cnt
);

    localparam int unsigned NumBanks = 4;
    localparam int unsigned FullAw   = 24;

    sdram_cmd_e          cmd;
    logic [NumBanks-1:0] bank_act;
    logic [NumBanks-1:0] bank_pre;
    logic [NumBanks-1:0] bank_active;
    logic [NumBanks-1:0] bank_trcd_ok;
    logic [12:0]         bank_row [NumBanks];

    logic        sel_active;
    logic [12:0] sel_row;
    logic        any_active;
    logic        access_ok;
    logic        rd_ok;
    logic        wr_ok;
    logic        lmr_ok;

    logic [FullAw-1:0] full_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic [15:0]       mem [2**MEM_AW];
    logic [15:0]       rd_word;

    logic [12:0] mode_q;
    logic        mode_valid_q;
    logic [15:0] refresh_q;
    rd_slot_t    slot_q [MaxCl];
    rd_slot_t    slot_d [MaxCl];
    rd_slot_t    out_q;
    rd_slot_t    out_d;

    assign cmd = sd_ncs ? CmdNop : sdram_cmd_e'({sd_nras, sd_ncas, sd_nwe});

    assign sel_active = bank_active[sd_ba];
    assign sel_row    = bank_row[sd_ba];
    assign any_active = |bank_active;

    assign access_ok = ((cmd == CmdRead) || (cmd == CmdWrite)) && mode_valid_q && sel_active;
    assign rd_ok     = access_ok && (cmd == CmdRead);
    assign wr_ok     = access_ok && (cmd == CmdWrite);
    assign lmr_ok    = (cmd == CmdLoadMode) && !any_active;

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        // Explicit precharge (single or all) or auto-precharge on a legal access.
        assign bank_act[b] = (cmd == CmdActive) && (sd_ba == 2'(b));
        assign bank_pre[b] = ((cmd == CmdPrecharge) && (sd_a[10] || (sd_ba == 2'(b))))
                           || (access_ok && sd_a[10] && (sd_ba == 2'(b)));

        sdram_model_bank #(
            .TRCD(TRCD)
        ) u_bank (
            .clk    (clk),
            .reset  (reset),
            .act    (bank_act[b]),
            .pre    (bank_pre[b]),
            .row_in (sd_a),
            .active (bank_active[b]),
            .row    (bank_row[b]),
            .trcd_ok(bank_trcd_ok[b])
        );
    end

    assign full_idx = {sd_ba, sel_row, sd_a[8:0]};
    assign mem_idx  = full_idx[MEM_AW-1:0];
    assign rd_word  = mem[mem_idx];

    // Backing array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (!sd_dqmh) mem[mem_idx][15:8] <= sd_dq_in[15:8];
            if (!sd_dqml) mem[mem_idx][7:0]  <= sd_dq_in[7:0];
        end
    end

    // Slot i reaches the output register i+1 edges after being loaded.
    always_comb begin
        slot_d[0] = slot_q[1];
        slot_d[1] = slot_q[2];
        slot_d[2] = '0;
        if (rd_ok) begin
            if (cas_latency(mode_q) == 3) begin
                slot_d[2] = '{vld: 1'b1, data: rd_word};
            end else begin
                slot_d[1] = '{vld: 1'b1, data: rd_word};
            end
        end
        // A WRITE on the bus wins over the read word due in this cycle.
        out_d = (cmd == CmdWrite) ? '0 : slot_q[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MaxCl; i++) slot_q[i] <= '0;
            out_q        <= '0;
            mode_q       <= '0;
            mode_valid_q <= 1'b0;
            refresh_q    <= '0;
        end else begin
            for (int i = 0; i < MaxCl; i++) slot_q[i] <= slot_d[i];
            out_q <= out_d;
            if (lmr_ok) begin
                mode_q       <= sd_a;
                mode_valid_q <= 1'b1;
            end
            if (cmd == CmdRefresh) refresh_q <= refresh_q + 16'd1;
        end
    end

    assign sd_dq_oe    = out_q.vld;
    assign sd_dq_out   = out_q.data;
    assign refresh_cnt = refresh_q;

`ifdef SDRAM_MODEL_CHECK_EN
    logic      sel_trcd_ok;
    err_code_t viol;
    logic      err_q;
    err_code_t err_code_q;

    assign sel_trcd_ok = bank_trcd_ok[sd_ba];

    always_comb begin
        viol = ErrNone;
        case (cmd)
            CmdRead, CmdWrite: begin
                if (!mode_valid_q)     viol = ErrNoMode;
                else if (!sel_active)  viol = ErrIdleBank;
                else if (!sel_trcd_ok) viol = ErrTrcd;
            end
            CmdActive:  if (sel_active) viol = ErrBankActive;
            CmdRefresh: if (any_active) viol = ErrNotIdle;
            CmdLoadMode: begin
                if (any_active)                viol = ErrNotIdle;
                else if (!mode_supported(sd_a)) viol = ErrBadMode;
            end
            default: viol = ErrNone;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else if (!err_q && (viol != ErrNone)) begin
            err_q      <= 1'b1;
            err_code_q <= viol;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
`else
    logic unused_trcd_ok;
    assign unused_trcd_ok = ^bank_trcd_ok;
    assign err            = 1'b0;
    assign err_code       = 3'd0;
`endif

endmodule
